fetch_stage: RTL and testbench

- First pipeline stage, directly upstream of decode.
- Owns the PC and drives the instruction-memory read handshake.
- Predicts conditional branches with a gshare pattern history table and redirects JAL statically.
- Presents the instruction word plus a fetch_decode_block (pc_reg, branch_guess, branch_history, jump_det) to decode.
- Accepts mispredict redirects and predictor training from execute.

---
 rtl/fetch_stage.sv | 192 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, runs the instruction-memory read handshake, predicts conditional
// branches with a gshare PHT, redirects JAL statically and registers the fetched word for decode.
// out_block layout (MSB..LSB): {pc_reg[31:0], branch_guess, branch_history[HIST_BITS-1:0], jump_det}
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000060,
  parameter int unsigned HIST_BITS = 8,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_stall,
  input  logic                   flush,
  input  logic [31:0]            redirect_pc,
  input  logic                   bp_update,
  input  logic [31:0]            bp_update_pc,
  input  logic [HIST_BITS-1:0]   bp_update_history,
  input  logic                   bp_update_taken,
  output logic                   imem_read,
  output logic [31:0]            imem_address,
  input  logic [31:0]            imem_rdata,
  input  logic                   imem_resp,
  output logic [31:0]            instr,
  output logic [HIST_BITS+33:0]  out_block
);

  localparam int unsigned BlkW    = HIST_BITS + 34;
  localparam int unsigned PhtSize = 1 << HIST_BITS;

  typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;          // address of the outstanding/next request
  logic [31:0]           target_q, target_d;  // redirect target parked while discarding
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [1:0]            pht_q [PhtSize];
  logic [31:0]           instr_q, instr_d;
  logic [BlkW-1:0]       blk_q, blk_d;
  logic [31:0]           skid_instr_q, skid_instr_d;
  logic [BlkW-1:0]       skid_blk_q, skid_blk_d;
  logic [31:0]           skid_next_q, skid_next_d;

  logic [31:0]           b_imm, j_imm, pred_next;
  logic [HIST_BITS-1:0]  pred_idx, upd_idx;
  logic                  pred_guess, pred_jump;
  logic [BlkW-1:0]       pred_blk;
  logic [1:0]            upd_cnt;
  logic                  unused_bits;

  assign unused_bits = ^{bp_update_pc[31:HIST_BITS+2], bp_update_pc[1:0]};

  assign b_imm = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7], imem_rdata[30:25],
                  imem_rdata[11:8], 1'b0};
  assign j_imm = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12], imem_rdata[20],
                  imem_rdata[30:21], 1'b0};

  // Predict on the returning word using the PC of the request it answers.
  always_comb begin
    pred_idx   = pc_q[HIST_BITS+1:2] ^ ghr_q;
    pred_guess = 1'b0;
    pred_jump  = 1'b0;
    pred_next  = pc_q + 32'd4;
    case (imem_rdata[6:0])
      7'b1100011: begin
        pred_guess = pht_q[pred_idx][1];
        if (pred_guess) pred_next = pc_q + b_imm;
      end
      7'b1101111: begin
        pred_jump = 1'b1;
        pred_next = pc_q + j_imm;
      end
      default: ;
    endcase
    pred_blk = {pc_q, pred_guess, ghr_q, pred_jump};
  end

  // Saturating counter training and non-speculative history shift.
  always_comb begin
    upd_idx = bp_update_pc[HIST_BITS+1:2] ^ bp_update_history;
    upd_cnt = pht_q[upd_idx];
    if (bp_update_taken) begin
      if (upd_cnt != 2'b11) upd_cnt = upd_cnt + 2'd1;
    end else begin
      if (upd_cnt != 2'b00) upd_cnt = upd_cnt - 2'd1;
    end
    ghr_d = ghr_q;
    if (bp_update) ghr_d = {ghr_q[HIST_BITS-2:0], bp_update_taken};
  end

  // Fetch FSM next-state and memory request outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    instr_d      = instr_q;
    blk_d        = blk_q;
    skid_instr_d = skid_instr_q;
    skid_blk_d   = skid_blk_q;
    skid_next_d  = skid_next_q;
    imem_read    = !rst && (state_q != StHold);
    imem_address = pc_q;

    if (flush) begin
      instr_d = NOP_INSTR;
      blk_d   = '0;
      if (state_q != StHold && !imem_resp) begin
        // Request still in flight: keep the address stable and drop its data later.
        state_d  = StDiscard;
        target_d = redirect_pc;
      end else begin
        state_d = StFetch;
        pc_d    = redirect_pc;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_resp) begin
            if (pipe_stall) begin
              skid_instr_d = imem_rdata;
              skid_blk_d   = pred_blk;
              skid_next_d  = pred_next;
              state_d      = StHold;
            end else begin
              instr_d = imem_rdata;
              blk_d   = pred_blk;
              pc_d    = pred_next;
            end
          end else if (!pipe_stall) begin
            instr_d = NOP_INSTR;
            blk_d   = '0;
          end
        end
        StHold: begin
          if (!pipe_stall) begin
            instr_d = skid_instr_q;
            blk_d   = skid_blk_q;
            pc_d    = skid_next_q;
            state_d = StFetch;
          end
        end
        StDiscard: begin
          if (imem_resp) begin
            state_d = StFetch;
            pc_d    = target_q;
          end
          if (!pipe_stall) begin
            instr_d = NOP_INSTR;
            blk_d   = '0;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // State, PC, history and decode-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      target_q     <= RESET_PC;
      ghr_q        <= '0;
      instr_q      <= NOP_INSTR;
      blk_q        <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_blk_q   <= '0;
      skid_next_q  <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      ghr_q        <= ghr_d;
      instr_q      <= instr_d;
      blk_q        <= blk_d;
      skid_instr_q <= skid_instr_d;
      skid_blk_q   <= skid_blk_d;
      skid_next_q  <= skid_next_d;
    end
  end

  // PHT: reset to weakly not-taken; prediction reads the pre-update value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PhtSize; i++) pht_q[i] <= 2'b01;
    end else if (bp_update) begin
      pht_q[upd_idx] <= upd_cnt;
    end
  end

  assign instr     = instr_q;
  assign out_block = blk_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a transaction-level model predicts every word
// delivered to decode and every memory request address.
module tb_fetch_stage;

  localparam int unsigned HB   = 8;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] RPC  = 32'h00000060;
  localparam int          NCYC = 3000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        guess;
    logic [7:0]  hist;
    logic        jump;
  } item_t;

  logic          clk, rst, pipe_stall, flush, bp_update, bp_update_taken;
  logic [31:0]   redirect_pc, bp_update_pc, imem_address, imem_rdata, instr;
  logic [HB-1:0] bp_update_history;
  logic          imem_read, imem_resp;
  logic [HB+33:0] out_block;

  fetch_stage #(.RESET_PC(RPC), .HIST_BITS(HB), .NOP_INSTR(NOP)) dut (
    .clk               (clk),
    .rst               (rst),
    .pipe_stall        (pipe_stall),
    .flush             (flush),
    .redirect_pc       (redirect_pc),
    .bp_update         (bp_update),
    .bp_update_pc      (bp_update_pc),
    .bp_update_history (bp_update_history),
    .bp_update_taken   (bp_update_taken),
    .imem_read         (imem_read),
    .imem_address      (imem_address),
    .imem_rdata        (imem_rdata),
    .imem_resp         (imem_resp),
    .instr             (instr),
    .out_block         (out_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int delivered = 0;

  // Reference model state
  int          pht [256];
  logic [7:0]  ghr;
  logic [31:0] exp_pc;
  bit          drop_pend;
  bit          parked_v;
  item_t       parked;
  logic [31:0] parked_next;
  item_t       exp_q[$];

  // Memory responder state
  bit          busy;
  int          cnt;
  logic [31:0] maddr;
  int          stall_run;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Memory image: instruction kind and offset are derived from a hash of the address.
  function automatic void gen(input logic [31:0] a, output logic [31:0] w, output int kind,
                              output int off);
    logic [31:0] h;
    logic [12:0] b;
    logic [20:0] j;
    int o;
    h    = (a >> 2) * 32'h9E3779B1;
    kind = int'(h[31:29]);
    o    = (int'(h[19:16]) - 4) * 4;
    off  = o;
    b    = o[12:0];
    j    = o[20:0];
    case (kind)
      3, 4:    w = {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], 7'b1100011};
      5:       w = {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
      6:       w = 32'h00008067;
      7:       w = 32'h000012b7;
      default: w = 32'h00100093;
    endcase
  endfunction

  task automatic predict(input logic [31:0] pc, output item_t it, output logic [31:0] nxt);
    logic [31:0] w;
    int kind, off, idx;
    gen(pc, w, kind, off);
    it.instr = w;
    it.pc    = pc;
    it.hist  = ghr;
    it.guess = 1'b0;
    it.jump  = 1'b0;
    nxt      = pc + 32'd4;
    if (kind == 3 || kind == 4) begin
      idx      = int'((pc >> 2) & 32'hFF) ^ int'(ghr);
      it.guess = (pht[idx] >= 2);
      if (it.guess) nxt = pc + 32'(off);
    end else if (kind == 5) begin
      it.jump = 1'b1;
      nxt     = pc + 32'(off);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) pht[i] = 1;
    ghr       = '0;
    exp_pc    = RPC;
    drop_pend = 0;
    parked_v  = 0;
    exp_q.delete();
  endtask

  // One clock edge of the model, using the inputs the DUT saw at that edge.
  task automatic model_step();
    item_t it;
    logic [31:0] nxt;
    int uidx;
    if (rst) begin
      model_reset();
      return;
    end
    if (flush) begin
      exp_pc    = redirect_pc;
      parked_v  = 0;
      drop_pend = busy;
    end else if (drop_pend && imem_resp) begin
      drop_pend = 0;
    end else if (parked_v && !pipe_stall) begin
      exp_q.push_back(parked);
      exp_pc   = parked_next;
      parked_v = 0;
    end else if (imem_resp) begin
      predict(exp_pc, it, nxt);
      if (pipe_stall) begin
        parked      = it;
        parked_next = nxt;
        parked_v    = 1;
      end else begin
        exp_q.push_back(it);
        exp_pc = nxt;
      end
    end
    if (bp_update) begin
      uidx = int'((bp_update_pc >> 2) & 32'hFF) ^ int'(bp_update_history);
      if (bp_update_taken) pht[uidx] = (pht[uidx] == 3) ? 3 : pht[uidx] + 1;
      else                 pht[uidx] = (pht[uidx] == 0) ? 0 : pht[uidx] - 1;
      ghr = {ghr[6:0], bp_update_taken};
    end
  endtask

  task automatic drive(input int n);
    rst = (n < 3) || (n >= 1500 && n < 1502);
    if (rst) begin
      pipe_stall = 0;
      flush      = 0;
      bp_update  = 0;
      stall_run  = 0;
    end else begin
      if (stall_run > 0) stall_run--;
      else if ($urandom_range(0, 19) == 0) stall_run = $urandom_range(1, 4);
      pipe_stall        = (stall_run > 0) || ($urandom_range(0, 5) == 0);
      flush             = ($urandom_range(0, 15) == 0);
      redirect_pc       = 32'h100 + 32'($urandom_range(0, 255)) * 4;
      bp_update         = ($urandom_range(0, 2) == 0);
      bp_update_pc      = ($urandom_range(0, 1) == 1) ? exp_pc
                                                      : 32'h60 + 32'($urandom_range(0, 63)) * 4;
      bp_update_history = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ghr;
      bp_update_taken   = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic mem_step();
    logic [31:0] w;
    int k, o;
    if (rst) begin
      busy      = 0;
      imem_resp = 0;
      return;
    end
    if (imem_resp) begin
      imem_resp  = 0;
      imem_rdata = $urandom;
    end else if (busy) begin
      cnt--;
      if (cnt == 0) begin
        gen(maddr, w, k, o);
        imem_rdata = w;
        imem_resp  = 1;
        busy       = 0;
      end
    end
    if (!busy && !imem_resp && imem_read) begin
      chk("addr", imem_address, exp_pc);
      maddr = imem_address;
      busy  = 1;
      cnt   = $urandom_range(1, 4);
    end
    if (parked_v) chk("hold_read", imem_read, 1'b0);
  endtask

  // Monitor: compares what decode sees after every edge against the scoreboard.
  initial begin : monitor
    item_t last, ex, bub;
    logic r, s, f;
    bub       = '0;
    bub.instr = NOP;
    last      = bub;
    forever begin
      @(posedge clk);
      r = rst;
      s = pipe_stall;
      f = flush;
      #1;
      if (r) begin
        ex = bub;
        chk("rst_read", imem_read, 1'b0);
      end else if (f) begin
        ex = bub;
      end else if (s) begin
        ex = last;
      end else if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        delivered++;
      end else begin
        ex = bub;
      end
      chk(r ? "rst_out" : "out", {instr, out_block}, ex);
      last = ex;
    end
  end

  // Stimulus, memory responder and model stepping.
  initial begin : stimulus
    rst = 1; pipe_stall = 0; flush = 0; redirect_pc = '0;
    bp_update = 0; bp_update_pc = '0; bp_update_history = '0; bp_update_taken = 0;
    imem_rdata = '0; imem_resp = 0;
    busy = 0; cnt = 0; maddr = '0; stall_run = 0;
    model_reset();
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      drive(n);
      #1;
      mem_step();
    end
    @(posedge clk);
    model_step();
    #2;
    chk("drain", 128'(exp_q.size()), 128'd0);
    chk("progress", 128'(delivered >= 100), 128'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
